// File: rtl/ether_ctrl_pkg.sv
// Shared types and helpers for the Ethernet commit/rollback gate.
package ether_ctrl_pkg;

  typedef enum logic {COLLECT, POISON} frame_state_t;
  typedef enum logic [1:0] {IDLE, EMIT, WAIT} drain_state_t;

  function automatic int PTR_W(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/commit_gate_ram.sv
// DEPTHx32 simple dual-port buffer: one write port, one registered read port.
module commit_gate_ram #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register is cleared on reset so the bus fields come up as zero.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ether_commit_gate.sv
// Buffers a frame's bus words, releases them on a good checksum verdict and
// rolls them back on a bad or overflowed frame; drains with a minimum strobe gap.
module ether_commit_gate
  import ether_ctrl_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int GAP   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        axiiv,
  input  logic [31:0] axiid,
  input  logic        done,
  input  logic        kill,
  output logic [15:0] addr_o,
  output logic [15:0] data_o,
  output logic        rw_o,
  output logic        valid_o,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_bad
);

  localparam int PW = PTR_W(DEPTH);
  localparam int AW = PW - 1;
  localparam int CW = (GAP < 1) ? 1 : $clog2(GAP + 1);

  logic [PW-1:0] wr, cm, rd, occ;
  frame_state_t  fstate;
  drain_state_t  dstate;
  logic [CW-1:0] gcnt;
  logic          we, re, full, poison_now;
  logic [31:0]   rdata;

  assign occ  = wr - rd;
  assign full = (occ == PW'(DEPTH));
  assign we   = axiiv && (fstate == COLLECT) && !full;
  // A word arriving alongside done can still poison the frame it ends.
  assign poison_now = (fstate == POISON) || (axiiv && full);
  assign re   = (dstate == IDLE) && (rd != cm);

  assign rw_o   = 1'b1;
  assign addr_o = rdata[31:16];
  assign data_o = rdata[15:0];

  commit_gate_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (wr[AW-1:0]),
    .wdata (axiid),
    .re    (re),
    .raddr (rd[AW-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fstate     <= COLLECT;
      wr         <= '0;
      cm         <= '0;
      frames_ok  <= '0;
      frames_bad <= '0;
    end else if (done) begin
      if (!kill && !poison_now) begin
        wr        <= wr + PW'(we);
        cm        <= wr + PW'(we);
        frames_ok <= sat_inc(frames_ok);
      end else begin
        wr         <= cm;
        frames_bad <= sat_inc(frames_bad);
      end
      fstate <= COLLECT;
    end else begin
      if (we)         wr     <= wr + PW'(1);
      if (poison_now) fstate <= POISON;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dstate  <= IDLE;
      rd      <= '0;
      valid_o <= 1'b0;
      gcnt    <= '0;
    end else begin
      case (dstate)
        IDLE: begin
          if (re) begin
            rd      <= rd + PW'(1);
            valid_o <= 1'b1;
            dstate  <= EMIT;
          end
        end
        EMIT: begin
          valid_o <= 1'b0;
          if (GAP == 0) begin
            dstate <= IDLE;
          end else begin
            gcnt   <= CW'(GAP);
            dstate <= WAIT;
          end
        end
        WAIT: begin
          if (gcnt <= CW'(1)) dstate <= IDLE;
          else                gcnt   <= gcnt - CW'(1);
        end
        default: dstate <= IDLE;
      endcase
    end
  end

endmodule
